// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmit and receive paths.
//   UART_DATA_SIZE : data bits per frame (matches the TX FIFO width)
//   UART_DIV_SIZE  : width of the programmable baud divisor
//   uart_state_e   : serializer frame states
// Build option: UART_TX_PARITY_EN adds the PARITY state.
package uart_pkg;

  localparam int UART_DATA_SIZE = 8;
  localparam int UART_DIV_SIZE  = 16;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_STOP   = 3'd4
  } uart_state_e;
`endif

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period timer.
//   clock : sole clock, rising edge
//   reset : asynchronous, active-low
//   clear : restart the period (count back to 0) on the next edge
//   div   : divisor; a period lasts div+1 cycles
//   tick  : high during the last cycle of each period
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int DIV_SIZE = UART_DIV_SIZE
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                clear,
  input  logic [DIV_SIZE-1:0] div,
  output logic                tick
);

  logic [DIV_SIZE-1:0] cnt_q;
  logic [DIV_SIZE-1:0] cnt_d;

  assign tick = (cnt_q == div);

  always_comb begin
    cnt_d = cnt_q + DIV_SIZE'(1);
    if (clear || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: pops bytes from the TX FIFO and sends them LSB-first
// as asynchronous frames (start, data, optional parity, 1 or 2 stop bits).
//   clock, reset            : clock and asynchronous active-low reset
//   tx_en                   : allow new frames to start
//   nstop                   : 0 = one stop bit, 1 = two stop bits
//   div                     : bit period is div+1 cycles
//   fifo_empty/fifo_rd_data : TX FIFO head (combinational)
//   fifo_rd_en              : one-cycle pop strobe
//   txd                     : serial line, idle high (registered)
//   busy                    : frame in progress (registered)
// Build option: UART_TX_PARITY_EN adds parity_en/parity_odd and a parity bit.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DATA_SIZE = UART_DATA_SIZE,
  parameter int DIV_SIZE  = UART_DIV_SIZE
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 tx_en,
  input  logic                 nstop,
  input  logic [DIV_SIZE-1:0]  div,
`ifdef UART_TX_PARITY_EN
  input  logic                 parity_en,
  input  logic                 parity_odd,
`endif
  input  logic                 fifo_empty,
  input  logic [DATA_SIZE-1:0] fifo_rd_data,
  output logic                 fifo_rd_en,
  output logic                 txd,
  output logic                 busy
);

  localparam int CNT_W = $clog2(DATA_SIZE + 1);

  uart_state_e          state_q,   state_d;
  logic [DATA_SIZE-1:0] shift_q,   shift_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic [DIV_SIZE-1:0]  div_q,     div_d;
  logic                 nstop_q,   nstop_d;
  logic                 txd_q,     txd_d;
  logic                 busy_q,    busy_d;
`ifdef UART_TX_PARITY_EN
  logic                 par_en_q,  par_en_d;
  logic                 par_bit_q, par_bit_d;
`endif

  logic pop;
  logic clear;
  logic tick;

  uart_baud_gen #(.DIV_SIZE(DIV_SIZE)) u_baud (
    .clock (clock),
    .reset (reset),
    .clear (clear),
    .div   (div_q),
    .tick  (tick)
  );

  // The pop strobe is combinational; gating with reset keeps it quiet while
  // reset is held even though the state decode would otherwise request one.
  assign fifo_rd_en = pop & reset;
  assign txd        = txd_q;
  assign busy       = busy_q;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    div_d      = div_q;
    nstop_d    = nstop_q;
`ifdef UART_TX_PARITY_EN
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
`endif
    pop        = 1'b0;
    clear      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Hold the baud counter at 0 so the start bit gets a full period.
        clear = 1'b1;
        if (tx_en && !fifo_empty) begin
          pop = 1'b1;
        end
      end
      ST_START: begin
        if (tick) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (tick) begin
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (bit_cnt_q == CNT_W'(DATA_SIZE - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_d = par_en_q ? ST_PARITY : ST_STOP;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (tick) state_d = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (tick) begin
          if (nstop_q && !stop_cnt_q) begin
            stop_cnt_d = 1'b1;
          end else if (tx_en && !fifo_empty) begin
            // Chain straight into the next frame with no idle gap.
            pop = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Everything describing a frame is captured at the pop, so control
    // register changes mid-frame only affect the following frame.
    if (pop) begin
      state_d    = ST_START;
      shift_d    = fifo_rd_data;
      bit_cnt_d  = '0;
      stop_cnt_d = 1'b0;
      div_d      = div;
      nstop_d    = nstop;
      clear      = 1'b1;
`ifdef UART_TX_PARITY_EN
      par_en_d   = parity_en;
      par_bit_d  = (^fifo_rd_data) ^ parity_odd;
`endif
    end

    // Outputs are registered: derive them from the state being entered.
    busy_d = (state_d != ST_IDLE);
    case (state_d)
      ST_START:  txd_d = 1'b0;
      ST_DATA:   txd_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: txd_d = par_bit_d;
`endif
      default:   txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      div_q      <= '0;
      nstop_q    <= 1'b0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      div_q      <= div_d;
      nstop_q    <= nstop_d;
      txd_q      <= txd_d;
      busy_q     <= busy_d;
`ifdef UART_TX_PARITY_EN
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
`endif
    end
  end

endmodule
